// File: rtl/axi_pkg.sv
// Shared AXI read-channel types and widths for the read arbiter and its helpers.
package axi_pkg;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 256;
  localparam int LEN_W   = 8;
  localparam int SIZE_W  = 3;
  localparam int CACHE_W = 4;
  localparam int PROT_W  = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AR   = 2'd1,
    R    = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [LEN_W-1:0]   len;
    logic [SIZE_W-1:0]  size;
    logic [CACHE_W-1:0] cache;
    logic [PROT_W-1:0]  prot;
  } ar_req_t;

  // Round-robin successor of a grant, never landing on the priority requester.
  function automatic int next_rr(input int grant, input int num_req, input int prio);
    int n;
    n = (grant + 1) % num_req;
    if (n == prio) n = (n + 1) % num_req;
    return n;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational pick: the priority requester wins unless the starvation counter
// is saturated while others wait, otherwise round robin over the rest.
module rr_priority_pick #(
  parameter int NUM_REQ  = 2,
  parameter int PRIO_REQ = 0,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [IDX_W-1:0]   rr_ptr_i,
  input  logic               starve_sat_i,
  output logic [IDX_W-1:0]   grant_o,
  output logic               found_o,
  output logic               others_valid_o
);

  logic [NUM_REQ-1:0] others;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    others           = valid_i;
    others[PRIO_REQ] = 1'b0;
    grant_o          = '0;
    found_o          = 1'b0;
    if (valid_i[PRIO_REQ] && (!starve_sat_i || others == '0)) begin
      grant_o = IDX_W'(PRIO_REQ);
      found_o = 1'b1;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found_o && others[IDX_W'((int'(rr_ptr_i) + i) % NUM_REQ)]) begin
          grant_o = IDX_W'((int'(rr_ptr_i) + i) % NUM_REQ);
          found_o = 1'b1;
        end
      end
    end
  end

  assign others_valid_o = |others;

endmodule

// File: rtl/axi_read_arbiter.sv
// Shares one AXI read master between NUM_REQ requesters, one burst at a time,
// favouring PRIO_REQ with a starvation bound for the others.
module axi_read_arbiter
  import axi_pkg::*;
#(
  parameter int NUM_REQ  = 2,
  parameter int PRIO_REQ = 0,
  parameter int MAX_WAIT = 8
) (
  input  logic                              ACLK,
  input  logic                              ARESET,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0]    S_ARADDR,
  input  logic [NUM_REQ-1:0][LEN_W-1:0]     S_ARLEN,
  input  logic [NUM_REQ-1:0][SIZE_W-1:0]    S_ARSIZE,
  input  logic [NUM_REQ-1:0][CACHE_W-1:0]   S_ARCACHE,
  input  logic [NUM_REQ-1:0][PROT_W-1:0]    S_ARPROT,
  input  logic [NUM_REQ-1:0]                S_ARVALID,
  output logic [NUM_REQ-1:0]                S_ARREADY,
  output logic [DATA_W-1:0]                 S_RDATA,
  output logic [NUM_REQ-1:0]                S_RLAST,
  output logic [NUM_REQ-1:0]                S_RVALID,
  input  logic [NUM_REQ-1:0]                S_RREADY,
  output logic [ADDR_W-1:0]                 M_ARADDR,
  output logic [LEN_W-1:0]                  M_ARLEN,
  output logic [SIZE_W-1:0]                 M_ARSIZE,
  output logic [CACHE_W-1:0]                M_ARCACHE,
  output logic [PROT_W-1:0]                 M_ARPROT,
  output logic                              M_ARVALID,
  input  logic                              M_ARREADY,
  input  logic [DATA_W-1:0]                 M_RDATA,
  input  logic                              M_RLAST,
  input  logic                              M_RVALID,
  output logic                              M_RREADY,
  output logic                              ERR
);

  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int SW     = $clog2(MAX_WAIT + 1);
  localparam int BEAT_W = 9;

  arb_state_t        state_q, state_d;
  logic [IDX_W-1:0]  grant_q, grant_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [BEAT_W-1:0] beat_total_q, beat_total_d;
  ar_req_t           ar_q, ar_d;
  logic              err_q, err_d;

  logic [IDX_W-1:0]  pick_grant;
  logic              pick_found;
  logic              others_valid;
  logic              starve_sat;
  logic              r_hs;
  ar_req_t           in_req;

  assign starve_sat = (starve_q == SW'(MAX_WAIT));

  rr_priority_pick #(
    .NUM_REQ  (NUM_REQ),
    .PRIO_REQ (PRIO_REQ)
  ) u_pick (
    .valid_i        (S_ARVALID),
    .rr_ptr_i       (rr_ptr_q),
    .starve_sat_i   (starve_sat),
    .grant_o        (pick_grant),
    .found_o        (pick_found),
    .others_valid_o (others_valid)
  );

  assign in_req.addr  = S_ARADDR[pick_grant];
  assign in_req.len   = S_ARLEN[pick_grant];
  assign in_req.size  = S_ARSIZE[pick_grant];
  assign in_req.cache = S_ARCACHE[pick_grant];
  assign in_req.prot  = S_ARPROT[pick_grant];

  assign r_hs = M_RVALID & M_RREADY;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    starve_d     = starve_q;
    rr_ptr_d     = rr_ptr_q;
    beat_d       = beat_q;
    beat_total_d = beat_total_q;
    ar_d         = ar_q;
    err_d        = err_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d      = pick_grant;
          ar_d         = in_req;
          beat_total_d = BEAT_W'(in_req.len) + 9'd1;
          state_d      = AR;
          if (pick_grant == IDX_W'(PRIO_REQ)) begin
            if (others_valid && !starve_sat) starve_d = starve_q + SW'(1);
          end else begin
            starve_d = '0;
            rr_ptr_d = IDX_W'(next_rr(int'(pick_grant), NUM_REQ, PRIO_REQ));
          end
        end
      end
      AR: begin
        if (M_ARREADY) begin
          beat_d  = '0;
          state_d = R;
        end
      end
      R: begin
        if (r_hs) begin
          if (beat_q != '1) beat_d = beat_q + 9'd1;
          // A short burst flags on RLAST; a long one flags when the count runs out.
          if (M_RLAST) begin
            state_d = IDLE;
            if (beat_q != beat_total_q - 9'd1) err_d = 1'b1;
          end else if (beat_q + 9'd1 == beat_total_q) begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      starve_q <= '0;
      rr_ptr_q <= '0;
      beat_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      starve_q <= starve_d;
      rr_ptr_q <= rr_ptr_d;
      beat_q   <= beat_d;
      err_q    <= err_d;
    end
  end

  // NOTE: address/length payload is left unreset; it is always written in IDLE
  // before the FSM can expose it, so a reset would only add fan-out.
  always_ff @(posedge ACLK) begin
    ar_q         <= ar_d;
    beat_total_q <= beat_total_d;
  end

  assign M_ARADDR  = ar_q.addr;
  assign M_ARLEN   = ar_q.len;
  assign M_ARSIZE  = ar_q.size;
  assign M_ARCACHE = ar_q.cache;
  assign M_ARPROT  = ar_q.prot;
  assign M_ARVALID = (state_q == AR) && !ARESET;
  assign M_RREADY  = (state_q == R) && S_RREADY[grant_q] && !ARESET;
  assign S_RDATA   = M_RDATA;
  assign ERR       = err_q;

  always_comb begin
    S_ARREADY = '0;
    S_RVALID  = '0;
    S_RLAST   = '0;
    if (!ARESET) begin
      if (state_q == AR) S_ARREADY[grant_q] = M_ARREADY;
      if (state_q == R) begin
        S_RVALID[grant_q] = M_RVALID;
        S_RLAST[grant_q]  = M_RLAST;
      end
    end
  end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed bench for axi_read_arbiter: two requesters, requester 0 has priority.
module tb_axi_read_arbiter;

  logic              ACLK = 1'b0;
  logic              ARESET;
  logic [1:0][31:0]  S_ARADDR;
  logic [1:0][7:0]   S_ARLEN;
  logic [1:0][2:0]   S_ARSIZE;
  logic [1:0][3:0]   S_ARCACHE;
  logic [1:0][1:0]   S_ARPROT;
  logic [1:0]        S_ARVALID;
  logic [1:0]        S_ARREADY;
  logic [255:0]      S_RDATA;
  logic [1:0]        S_RLAST;
  logic [1:0]        S_RVALID;
  logic [1:0]        S_RREADY;
  logic [31:0]       M_ARADDR;
  logic [7:0]        M_ARLEN;
  logic [2:0]        M_ARSIZE;
  logic [3:0]        M_ARCACHE;
  logic [1:0]        M_ARPROT;
  logic              M_ARVALID;
  logic              M_ARREADY;
  logic [255:0]      M_RDATA;
  logic              M_RLAST;
  logic              M_RVALID;
  logic              M_RREADY;
  logic              ERR;

  int checks = 0;
  int errors = 0;

  axi_read_arbiter #(.NUM_REQ(2), .PRIO_REQ(0), .MAX_WAIT(8)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_ARADDR(S_ARADDR), .S_ARLEN(S_ARLEN), .S_ARSIZE(S_ARSIZE),
    .S_ARCACHE(S_ARCACHE), .S_ARPROT(S_ARPROT), .S_ARVALID(S_ARVALID),
    .S_ARREADY(S_ARREADY), .S_RDATA(S_RDATA), .S_RLAST(S_RLAST),
    .S_RVALID(S_RVALID), .S_RREADY(S_RREADY),
    .M_ARADDR(M_ARADDR), .M_ARLEN(M_ARLEN), .M_ARSIZE(M_ARSIZE),
    .M_ARCACHE(M_ARCACHE), .M_ARPROT(M_ARPROT), .M_ARVALID(M_ARVALID),
    .M_ARREADY(M_ARREADY), .M_RDATA(M_RDATA), .M_RLAST(M_RLAST),
    .M_RVALID(M_RVALID), .M_RREADY(M_RREADY), .ERR(ERR)
  );

  always #5 ACLK = ~ACLK;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Waits (bounded) for M_ARVALID and reports which requester sees S_ARREADY.
  task automatic wait_ar(output int gnt, output logic [31:0] addr);
    int n;
    n = 0;
    gnt = -1;
    #1;
    while (M_ARVALID !== 1'b1 && n < 20) begin
      @(negedge ACLK); #1; n++;
    end
    check("ar_wait", n < 20, 1'b1);
    addr = M_ARADDR;
    for (int j = 0; j < 2; j++) if (S_ARREADY[j]) gnt = j;
  endtask

  // One full transaction with M_ARREADY already high; slave sends last_at+1 beats.
  task automatic txn(input int last_at, input bit drop, input int stall_at,
                     input int stall_cyc, output int gnt, output int beats,
                     output logic [31:0] addr, output bit other_rv);
    beats = 0;
    other_rv = 1'b0;
    wait_ar(gnt, addr);
    if (gnt < 0) return;
    @(negedge ACLK);
    if (drop) S_ARVALID[gnt] = 1'b0;
    for (int i = 0; i <= last_at; i++) begin
      if (i == stall_at) begin
        for (int s = 0; s < stall_cyc; s++) begin
          M_RVALID = 1'b1; M_RLAST = 1'b0; S_RREADY = 2'b00; #1;
          check("stall_rready", M_RREADY, 1'b0);
          check("stall_beat", dut.beat_q, stall_at);
          @(negedge ACLK);
        end
      end
      S_RREADY = 2'b11;
      M_RVALID = 1'b1;
      M_RLAST  = (i == last_at);
      M_RDATA  = {8{32'hC0DE0000 + i}};
      #1;
      if (i == 0) begin
        check("r_rdata", S_RDATA[63:0], {2{32'hC0DE0000}});
        check("r_no_arready", S_ARREADY, 2'b00);
      end
      if (M_RREADY && S_RVALID[gnt]) beats++;
      for (int j = 0; j < 2; j++) if (j != gnt && S_RVALID[j]) other_rv = 1'b1;
      @(negedge ACLK);
    end
    M_RVALID = 1'b0;
    M_RLAST  = 1'b0;
  endtask

  task automatic pulse_reset();
    ARESET = 1'b1;
    @(negedge ACLK);
    ARESET = 1'b0;
  endtask

  int gnt, beats, exp_g;
  logic [31:0] addr;
  bit other_rv;

  initial begin
    ARESET = 1'b1;
    S_ARADDR = '0; S_ARLEN = '0; S_ARSIZE = '0; S_ARCACHE = '0; S_ARPROT = '0;
    S_ARVALID = '0; S_RREADY = 2'b11;
    M_ARREADY = 1'b1; M_RDATA = '0; M_RLAST = 1'b0; M_RVALID = 1'b0;
    S_ARSIZE[1] = 3'd5; S_ARCACHE[1] = 4'h3; S_ARPROT[1] = 2'd2;
    @(negedge ACLK); @(negedge ACLK); #1;
    check("rst_state", dut.state_q, 0);
    check("rst_err", ERR, 1'b0);
    check("rst_arvalid", M_ARVALID, 1'b0);
    check("rst_rready", M_RREADY, 1'b0);
    ARESET = 1'b0;

    // Test 1: single requester 1 burst of 4 beats.
    @(negedge ACLK);
    S_ARADDR[1] = 32'h1000; S_ARLEN[1] = 8'd3; S_ARVALID = 2'b10; #1;
    check("t1_arvalid_pre", M_ARVALID, 1'b0);
    @(negedge ACLK); #1;
    check("t1_arvalid_lat", M_ARVALID, 1'b1);
    check("t1_arlen", M_ARLEN, 8'd3);
    check("t1_arattr", {M_ARSIZE, M_ARCACHE, M_ARPROT}, {3'd5, 4'h3, 2'd2});
    txn(3, 1'b1, -1, 0, gnt, beats, addr, other_rv);
    check("t1_grant", gnt, 1);
    check("t1_addr", addr, 32'h1000);
    check("t1_beats", beats, 4);
    check("t1_rvalid0", other_rv, 1'b0);
    check("t1_err", ERR, 1'b0);

    // Test 2: both requesters valid, starvation bound of 8.
    S_ARADDR[0] = 32'hA000_0000; S_ARADDR[1] = 32'hB000_0000;
    S_ARLEN = '0; S_ARVALID = 2'b11;
    for (int k = 0; k < 18; k++) begin
      exp_g = (k % 9 == 8) ? 1 : 0;
      txn(0, 1'b0, -1, 0, gnt, beats, addr, other_rv);
      check("t2_grant", gnt, exp_g);
      check("t2_addr", addr, exp_g ? 32'hB000_0000 : 32'hA000_0000);
      if (k % 9 == 7) check("t2_starve_sat", dut.starve_q, 8);
      if (k % 9 == 8) check("t2_starve_clr", dut.starve_q, 0);
    end
    S_ARVALID = 2'b00;
    @(negedge ACLK);

    // Test 3: early RLAST on the third beat of a 4-beat burst.
    check("t3_err_pre", ERR, 1'b0);
    S_ARADDR[0] = 32'h3000; S_ARLEN[0] = 8'd3; S_ARVALID = 2'b01;
    txn(2, 1'b1, -1, 0, gnt, beats, addr, other_rv);
    check("t3_beats", beats, 3);
    check("t3_err", ERR, 1'b1);
    check("t3_idle", dut.state_q, 0);
    S_ARLEN[0] = 8'd0; S_ARVALID = 2'b01;
    txn(0, 1'b1, -1, 0, gnt, beats, addr, other_rv);
    check("t3_err_sticky", ERR, 1'b1);

    // Test 4: reset in the middle of a burst.
    S_ARADDR[0] = 32'h4000; S_ARLEN[0] = 8'd3; S_ARVALID = 2'b01;
    wait_ar(gnt, addr);
    @(negedge ACLK);
    S_ARVALID = 2'b00; M_RVALID = 1'b1; M_RLAST = 1'b0; #1;
    check("t4_rvalid", S_RVALID, 2'b01);
    @(negedge ACLK);
    ARESET = 1'b1; #1;
    check("t4_gate_rready", M_RREADY, 1'b0);
    check("t4_gate_rvalid", S_RVALID, 2'b00);
    @(negedge ACLK);
    ARESET = 1'b0; M_RVALID = 1'b0; #1;
    check("t4_idle", dut.state_q, 0);
    check("t4_err", ERR, 1'b0);
    check("t4_beat", dut.beat_q, 0);
    check("t4_rready", M_RREADY, 1'b0);
    S_ARADDR[1] = 32'h4400; S_ARLEN[1] = 8'd0; S_ARVALID = 2'b10;
    txn(0, 1'b1, -1, 0, gnt, beats, addr, other_rv);
    check("t4_new_grant", gnt, 1);
    check("t4_new_addr", addr, 32'h4400);
    check("t4_new_beats", beats, 1);
    check("t4_new_err", ERR, 1'b0);

    // Test 3b: slave overruns a 2-beat burst with 4 beats.
    S_ARADDR[0] = 32'h3800; S_ARLEN[0] = 8'd1; S_ARVALID = 2'b01;
    txn(3, 1'b1, -1, 0, gnt, beats, addr, other_rv);
    check("t3b_beats", beats, 4);
    check("t3b_err", ERR, 1'b1);
    check("t3b_idle", dut.state_q, 0);
    pulse_reset(); #1;
    check("t3b_err_clr", ERR, 1'b0);

    // Test 5: address channel stalled for 5 cycles on requester 1.
    M_ARREADY = 1'b0;
    S_ARADDR[1] = 32'h5000; S_ARLEN[1] = 8'd1; S_ARVALID = 2'b10;
    @(negedge ACLK);
    for (int c = 0; c < 5; c++) begin
      #1;
      check("t5_arvalid", M_ARVALID, 1'b1);
      check("t5_araddr", M_ARADDR, 32'h5000);
      check("t5_arready", S_ARREADY, 2'b00);
      if (c == 1) begin
        S_ARADDR[0] = 32'h5500; S_ARLEN[0] = 8'd0; S_ARVALID[0] = 1'b1;
      end
      @(negedge ACLK);
    end
    M_ARREADY = 1'b1; #1;
    check("t5_arready_rise", S_ARREADY, 2'b10);
    txn(1, 1'b1, -1, 0, gnt, beats, addr, other_rv);
    check("t5_grant", gnt, 1);
    check("t5_beats", beats, 2);
    txn(0, 1'b1, -1, 0, gnt, beats, addr, other_rv);
    check("t5_next_grant", gnt, 0);
    check("t5_next_addr", addr, 32'h5500);

    // Test 6: requester back-pressure for 3 cycles mid-burst.
    S_ARADDR[0] = 32'h6000; S_ARLEN[0] = 8'd3; S_ARVALID = 2'b01;
    txn(3, 1'b1, 1, 3, gnt, beats, addr, other_rv);
    check("t6_grant", gnt, 0);
    check("t6_beats", beats, 4);
    check("t6_err", ERR, 1'b0);

    @(negedge ACLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_read_arbiter.md
Name: axi_read_arbiter

Overview:
- Shares one 256-bit AXI read master port between NUM_REQ requesters, for example the framebuffer scanout engine and a DMA or blitter engine.
- Requester PRIO_REQ is the real-time requester (display scanout) and normally wins arbitration.
- A starvation counter guarantees forward progress for the other requesters.
- One transaction is outstanding at a time. The grant is held from address phase through the RLAST beat.

Parameters:
- NUM_REQ, 2, number of requester ports (2..4).
- PRIO_REQ, 0, index of the high-priority requester.
- MAX_WAIT, 8, consecutive priority grants allowed while another requester waits.

Ports:
- ACLK  in  1  clock; one clock; reset is synchronous and active-high.
- ARESET  in  1  synchronous active-high reset.
- S_ARADDR  in  NUM_REQ x 32  per-requester read address.
- S_ARLEN  in  NUM_REQ x 8  per-requester burst length minus 1.
- S_ARSIZE  in  NUM_REQ x 3  per-requester beat size.
- S_ARCACHE  in  NUM_REQ x 4  per-requester cache attributes.
- S_ARPROT  in  NUM_REQ x 2  per-requester protection attributes.
- S_ARVALID  in  NUM_REQ  request valid.
- S_ARREADY  out  NUM_REQ  request accepted.
- S_RDATA  out  256  read data, broadcast to all requesters.
- S_RLAST  out  NUM_REQ  last beat, granted requester only.
- S_RVALID  out  NUM_REQ  data valid, granted requester only.
- S_RREADY  in  NUM_REQ  requester data ready.
- M_ARADDR, M_ARLEN, M_ARSIZE, M_ARCACHE, M_ARPROT  out  32/8/3/4/2  downstream address channel.
- M_ARVALID  out  1  downstream address valid.
- M_ARREADY  in  1  downstream address ready.
- M_RDATA  in  256  downstream read data.
- M_RLAST  in  1  downstream last beat.
- M_RVALID  in  1  downstream data valid.
- M_RREADY  out  1  downstream data ready.
- ERR  out  1  sticky flag: beat count disagreed with RLAST.

Behaviour:
- States: IDLE, AR, R.
- Reset (ARESET high at a clock edge) takes effect at that edge:
  - state=IDLE, grant=0, starve=0, rr_ptr=0, beat=0, ERR=0.
  - M_ARVALID, S_ARREADY, S_RVALID and M_RREADY are gated low combinationally while ARESET is high.
- IDLE, arbitration, evaluated only when some S_ARVALID is high:
  - If S_ARVALID[PRIO_REQ] is high and either starve < MAX_WAIT or no other requester is valid: grant PRIO_REQ. If another requester is valid, starve increments (saturating at MAX_WAIT).
  - Otherwise grant the first valid non-priority requester at or after rr_ptr (round robin). Then starve=0 and rr_ptr = grant+1, skipping PRIO_REQ, wrapping modulo NUM_REQ.
  - Grant is registered and state moves to AR. Also in that cycle: latch the granted S_AR* fields into M_AR* registers, and latch beat_total = S_ARLEN+1.
  - Latency: first cycle S_ARVALID is seen -> M_ARVALID high on the next cycle.
- AR:
  - M_ARVALID=1.
  - S_ARREADY[grant] = M_ARREADY (combinational). All other S_ARREADY bits are 0.
  - On M_ARREADY: beat=0, go to R.
  - Requesters must hold S_AR* stable until S_ARREADY, per AXI rules.
- R:
  - M_RREADY = S_RREADY[grant].
  - S_RVALID[grant] = M_RVALID and S_RLAST[grant] = M_RLAST. Other bits are 0.
  - S_RDATA = M_RDATA.
  - On each handshake (M_RVALID & M_RREADY): beat increments.
  - On handshake with M_RLAST: go to IDLE.
  - ERR is set (sticky until reset) if M_RLAST arrives at beat != beat_total-1, or if beat reaches beat_total without M_RLAST. In the second case the arbiter still waits for M_RLAST.
- S_ARREADY is never high in IDLE or R. New requests stall until the burst completes.
- Back-to-back operation:
  - The IDLE cycle between transactions is mandatory.
  - Sustained throughput is one AR every (burst_len + 2 + AR wait) cycles.
- A requester that drops S_ARVALID before it is granted is simply not considered; this is legal only for the testbench.
- Width rules:
  - starve: $clog2(MAX_WAIT+1) bits, saturating.
  - beat: 9 bits, so ARLEN=255 gives a 256-beat count.
  - rr_ptr: $clog2(NUM_REQ) bits.

Decomposition:
- Shared package axi_pkg holds:
  - the arb_state_t enum (IDLE, AR, R),
  - AXI width constants (ADDR_W=32, DATA_W=256, LEN_W=8),
  - an ar_req_t struct bundling addr/len/size/cache/prot.
- One natural sub-module: rr_priority_pick. It is purely combinational. Inputs are the valid vector, rr_ptr, the starve-saturated flag and PRIO_REQ. Outputs are the grant index and a found flag.
- The FSM, counters and muxing stay in axi_read_arbiter.

Test Plan:
1. Only requester 1 requests addr 0x1000, ARLEN=3; M_ARREADY=1; M_RVALID beats 4 with RLAST on the 4th.
   - M_ARVALID rises 1 cycle after S_ARVALID[1].
   - M_ARADDR=0x1000.
   - S_RVALID[1] pulses 4 times; S_RVALID[0]=0.
   - ERR=0.
2. Both requesters valid continuously with MAX_WAIT=8, 1-beat bursts.
   - Grant sequence is 0 x8, then 1, then 0 x8, then 1.
   - starve resets to 0 after each grant to requester 1.
3. Requester 0 issues ARLEN=3, but the slave asserts RLAST on beat 2.
   - ERR=1 from the cycle after that beat.
   - State returns to IDLE.
   - ERR stays 1 until ARESET.
4. ARESET pulsed high in R state after beat 1 of 4.
   - Next cycle: state=IDLE, M_RREADY=0, all S_RVALID=0, ERR=0.
   - A new request is accepted normally afterwards.
5. M_ARREADY held low for 5 cycles with grant=1.
   - M_ARVALID stays 1 with M_ARADDR stable.
   - S_ARREADY[1] rises in the same cycle M_ARREADY rises.
   - A requester-0 request arriving meanwhile is not granted until after RLAST.
6. S_RREADY[0] deasserted for 3 cycles mid-burst.
   - M_RREADY=0 for those cycles.
   - beat does not advance.
   - Burst completes with ERR=0.
